// File: rtl/meas_point_pkg.sv
// Shared types and constants for the measurement point buffer.
//   meas_point_t : one queued point {ch, v, t} at the default widths
//   CH1 / CH2    : channel tag values carried in the ch field
package meas_point_pkg;

    localparam int V_WIDTH_DEF = 16;
    localparam int T_WIDTH_DEF = 10;

    localparam logic CH1 = 1'b0;
    localparam logic CH2 = 1'b1;

    typedef struct packed {
        logic                   ch;
        logic [V_WIDTH_DEF-1:0] v;
        logic [T_WIDTH_DEF-1:0] t;
    } meas_point_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO.
//   clk_i, arst_i : clock, asynchronous active-high reset
//   clr_i         : synchronous flush, overrides push/pop in the same cycle
//   push_i/data_i : write request and data (ignored when full unless popping)
//   pop_i         : consume head (ignored when empty)
//   data_o        : head entry, zero while empty
//   full_o, empty_o, count_o : occupancy status
module sync_fifo_fwft #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_reg == FULL_CNT);
    assign empty_o = (count_reg == '0);
    assign count_o = count_reg;

    // A pop frees a slot in the same cycle, so push is accepted when full
    // as long as a real pop happens alongside it.
    assign do_pop  = pop_i & ~empty_o & ~clr_i;
    assign do_push = push_i & ~clr_i & (~full_o | do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clr_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers/count.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_reg] <= data_i;
    end

    assign data_o = empty_o ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/meas_point_buf.sv
// Measurement point buffer: captures (threshold, delay) point pulses from two
// channels into per-channel holding registers, arbitrates them (channel 1
// first) into a FWFT FIFO, and counts points lost to occupied holding regs.
//   clk_i, arst_i       : measure clock, asynchronous active-high reset
//   clr_i               : synchronous flush of FIFO, holding regs, error state
//   chN_rdy_i/v_i/t_i   : point pulse and payload for channel N
//   pop_i               : consume head entry
//   valid_o, data_o     : FIFO non-empty, head entry {ch, v, t}
//   count_o             : stored entries
//   ovf_o, drop_cnt_o   : sticky drop flag, saturating drop counter
module meas_point_buf
    import meas_point_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int V_WIDTH        = 16,
    parameter int T_WIDTH        = 10,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                           clk_i,
    input  logic                           arst_i,
    input  logic                           clr_i,
    input  logic                           ch1_rdy_i,
    input  logic [V_WIDTH-1:0]             ch1_v_i,
    input  logic [T_WIDTH-1:0]             ch1_t_i,
    input  logic                           ch2_rdy_i,
    input  logic [V_WIDTH-1:0]             ch2_v_i,
    input  logic [T_WIDTH-1:0]             ch2_t_i,
    input  logic                           pop_i,
    output logic                           valid_o,
    output logic [V_WIDTH+T_WIDTH:0]       data_o,
    output logic [$clog2(DEPTH):0]         count_o,
    output logic                           ovf_o,
    output logic [DROP_CNT_WIDTH-1:0]      drop_cnt_o
);

    localparam int PW = V_WIDTH + T_WIDTH;
    localparam int DW = 1 + PW;
    localparam int SW = DROP_CNT_WIDTH + 1;

    logic [1:0]          rdy;
    logic [PW-1:0]       in_pt [2];
    logic [PW-1:0]       pend  [2];
    logic [1:0]          vld;
    logic [1:0]          wr;
    logic [1:0]          load;
    logic [1:0]          drop;

    logic                fifo_full;
    logic                fifo_empty;
    logic                pop_eff;
    logic                space;
    logic                push;
    logic [DW-1:0]       push_data;

    logic                ovf_reg;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_reg;
    logic [SW-1:0]       drop_sum;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_next;

    assign rdy      = {ch2_rdy_i, ch1_rdy_i};
    assign in_pt[0] = {ch1_v_i, ch1_t_i};
    assign in_pt[1] = {ch2_v_i, ch2_t_i};

    // A slot is available if not full, or if a genuine pop frees one now.
    assign pop_eff = pop_i & ~fifo_empty;
    assign space   = ~fifo_full | pop_eff;

    // Single write port: channel 1 wins, channel 2 waits its turn.
    assign wr[0]     = vld[0] & space;
    assign wr[1]     = ~vld[0] & vld[1] & space;
    assign push      = wr[0] | wr[1];
    assign push_data = wr[0] ? {CH1, pend[0]} : {CH2, pend[1]};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic          vld_reg;
            logic [PW-1:0] pend_reg;

            // A draining holding reg can accept a new point in the same cycle.
            assign load[gi] = rdy[gi] & (~vld_reg | wr[gi]);
            assign drop[gi] = rdy[gi] & ~load[gi];
            assign vld[gi]  = vld_reg;
            assign pend[gi] = pend_reg;

            always_ff @(posedge clk_i or posedge arst_i) begin
                if (arst_i) begin
                    vld_reg  <= 1'b0;
                    pend_reg <= '0;
                end else if (clr_i) begin
                    vld_reg  <= 1'b0;
                end else if (load[gi]) begin
                    vld_reg  <= 1'b1;
                    pend_reg <= in_pt[gi];
                end else if (wr[gi]) begin
                    vld_reg  <= 1'b0;
                end
            end
        end
    endgenerate

    // Both channels can drop in the same cycle, so the counter may step by 2.
    assign drop_sum      = {1'b0, drop_cnt_reg} + SW'(drop[0]) + SW'(drop[1]);
    assign drop_cnt_next = drop_sum[SW-1] ? '1 : drop_sum[DROP_CNT_WIDTH-1:0];

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            ovf_reg      <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (clr_i) begin
            ovf_reg      <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            if (|drop) ovf_reg <= 1'b1;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .clr_i   (clr_i),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop_i),
        .data_o  (data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_o)
    );

    assign valid_o    = ~fifo_empty;
    assign ovf_o      = ovf_reg;
    assign drop_cnt_o = drop_cnt_reg;

endmodule

// File: tb/tb_meas_point_buf.sv
module tb_meas_point_buf;
    import meas_point_pkg::*;

    localparam int DEPTH = 16;
    localparam int VW    = 16;
    localparam int TW    = 10;
    localparam int DCW   = 8;
    localparam int DROP_MAX = 255;

    logic          clk = 1'b0;
    logic          arst;
    logic          clr = 1'b0;
    logic          ch1_rdy = 1'b0, ch2_rdy = 1'b0, pop = 1'b0;
    logic [VW-1:0] ch1_v = '0, ch2_v = '0;
    logic [TW-1:0] ch1_t = '0, ch2_t = '0;

    logic          valid;
    logic [VW+TW:0] data;
    logic [4:0]    count;
    logic          ovf;
    logic [DCW-1:0] drop_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    meas_point_buf #(
        .DEPTH(DEPTH), .V_WIDTH(VW), .T_WIDTH(TW), .DROP_CNT_WIDTH(DCW)
    ) dut (
        .clk_i(clk), .arst_i(arst), .clr_i(clr),
        .ch1_rdy_i(ch1_rdy), .ch1_v_i(ch1_v), .ch1_t_i(ch1_t),
        .ch2_rdy_i(ch2_rdy), .ch2_v_i(ch2_v), .ch2_t_i(ch2_t),
        .pop_i(pop), .valid_o(valid), .data_o(data), .count_o(count),
        .ovf_o(ovf), .drop_cnt_o(drop_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model: queue + two optional points ----------
    meas_point_t mq[$];
    bit          p1v, p2v;
    logic [VW+TW-1:0] p1, p2;
    int          m_drop;
    bit          m_ovf;

    always @(posedge clk or posedge arst) begin : model
        bit pop_ok, room, w1, w2;
        int drops;
        if (arst) begin
            mq.delete(); p1v = 0; p2v = 0; m_drop = 0; m_ovf = 0;
        end else if (clr) begin
            mq.delete(); p1v = 0; p2v = 0; m_drop = 0; m_ovf = 0;
        end else begin
            pop_ok = pop && (mq.size() > 0);
            room   = (mq.size() < DEPTH) || pop_ok;
            w1 = p1v && room;
            w2 = !w1 && p2v && room;
            if (pop_ok) void'(mq.pop_front());
            if (w1) mq.push_back({CH1, p1});
            if (w2) mq.push_back({CH2, p2});
            drops = 0;
            if (ch1_rdy) begin
                if (!p1v || w1) begin p1 = {ch1_v, ch1_t}; p1v = 1; end
                else drops++;
            end else if (w1) p1v = 0;
            if (ch2_rdy) begin
                if (!p2v || w2) begin p2 = {ch2_v, ch2_t}; p2v = 1; end
                else drops++;
            end else if (w2) p2v = 0;
            if (drops > 0) m_ovf = 1;
            m_drop = (m_drop + drops > DROP_MAX) ? DROP_MAX : m_drop + drops;
        end
    end

    // ---------------- per-cycle compare against the model ---------------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("valid", 32'(valid), 32'(mq.size() > 0));
            check("data",  32'(data),  (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
            check("count", 32'(count), 32'(mq.size()));
            check("ovf",   32'(ovf),   32'(m_ovf));
            check("drop",  32'(drop_cnt), 32'(m_drop));
        end
    end

    // ---------------- stimulus helpers ----------------------------------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cyc(input bit r1, input logic [VW-1:0] v1, input logic [TW-1:0] t1,
                       input bit r2, input logic [VW-1:0] v2, input logic [TW-1:0] t2,
                       input bit p, input bit c);
        ch1_rdy = r1; ch1_v = v1; ch1_t = t1;
        ch2_rdy = r2; ch2_v = v2; ch2_t = t2;
        pop = p; clr = c;
        @(negedge clk);
        ch1_rdy = 0; ch2_rdy = 0; pop = 0; clr = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [VW+TW:0] lit;
        int pp;

        arst = 1'b1;
        idle(2);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ovf",   32'(ovf),   32'd0);
        check("rst_drop",  32'(drop_cnt), 32'd0);
        check("rst_data",  32'(data),  32'd0);
        arst = 1'b0;
        idle(1);
        chk_en = 1'b1;

        // Single point latency
        cyc(1, 16'h1234, 10'h05, 0, 0, 0, 0, 0);
        check("lat_n1_valid", 32'(valid), 32'd0);
        idle(1);
        lit = {1'b0, 16'h1234, 10'h005};
        check("lat_n2_valid", 32'(valid), 32'd1);
        check("lat_n2_data",  32'(data),  32'(lit));
        check("lat_n2_count", 32'(count), 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        check("pop_valid", 32'(valid), 32'd0);
        check("pop_count", 32'(count), 32'd0);

        // Simultaneous arrival
        cyc(1, 16'd1, 10'd1, 1, 16'd2, 10'd2, 0, 0);
        idle(2);
        lit = {1'b0, 16'd1, 10'd1};
        check("sim_count", 32'(count), 32'd2);
        check("sim_head1", 32'(data),  32'(lit));
        check("sim_ovf",   32'(ovf),   32'd0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        lit = {1'b1, 16'd2, 10'd2};
        check("sim_head2", 32'(data),  32'(lit));
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        check("sim_empty", 32'(count), 32'd0);

        // Fill and backpressure
        for (int i = 0; i < 16; i++) cyc(1, VW'(i), TW'(i), 0, 0, 0, 0, 0);
        idle(2);
        check("fill_count", 32'(count), 32'd16);
        cyc(1, 16'd16, 10'd16, 0, 0, 0, 0, 0);
        idle(1);
        check("held_ovf",   32'(ovf),   32'd0);
        check("held_count", 32'(count), 32'd16);
        cyc(1, 16'd17, 10'd17, 0, 0, 0, 0, 0);
        check("drop1_ovf",  32'(ovf),   32'd1);
        check("drop1_cnt",  32'(drop_cnt), 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        check("bp_count",   32'(count), 32'd16);
        check("bp_head_v",  32'(data[VW+TW-1:TW]), 32'd1);

        // Full push+pop with pend1 valid
        cyc(1, 16'd18, 10'd18, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        check("pp_count",   32'(count), 32'd16);
        check("pp_head_v",  32'(data[VW+TW-1:TW]), 32'd2);

        // Drop saturation then clear
        for (int i = 0; i < 160; i++)
            cyc(1, VW'(i), TW'(i), 1, VW'(i), TW'(i), 0, 0);
        check("sat_drop", 32'(drop_cnt), 32'hFF);
        check("sat_ovf",  32'(ovf), 32'd1);
        cyc(1, 16'd5, 10'd5, 1, 16'd6, 10'd6, 1, 1);
        check("clr_drop",  32'(drop_cnt), 32'd0);
        check("clr_ovf",   32'(ovf),   32'd0);
        check("clr_count", 32'(count), 32'd0);
        check("clr_valid", 32'(valid), 32'd0);
        idle(3);
        check("clr_no_pend", 32'(count), 32'd0);

        // Async reset mid-stream
        for (int i = 0; i < 5; i++) cyc(1, VW'(100 + i), TW'(i), 0, 0, 0, 0, 0);
        idle(2);
        check("ar_pre_count", 32'(count), 32'd5);
        cyc(0, 0, 0, 1, 16'd55, 10'd3, 0, 0);
        chk_en = 1'b0;
        #1 arst = 1'b1;
        #1;
        check("ar_valid", 32'(valid), 32'd0);
        check("ar_count", 32'(count), 32'd0);
        check("ar_ovf",   32'(ovf),   32'd0);
        check("ar_drop",  32'(drop_cnt), 32'd0);
        check("ar_data",  32'(data),  32'd0);
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        cyc(0, 0, 0, 1, 16'd77, 10'd9, 0, 0);
        idle(1);
        lit = {1'b1, 16'd77, 10'd9};
        check("ar_post_count", 32'(count), 32'd1);
        check("ar_post_data",  32'(data),  32'(lit));
        idle(2);
        check("ar_post_only",  32'(count), 32'd1);

        // Randomised traffic with varying drain rates
        for (int ph = 0; ph < 3; ph++) begin
            pp = (ph == 0) ? 50 : (ph == 1) ? 10 : 90;
            for (int i = 0; i < 1500; i++) begin
                cyc($urandom_range(99) < 30, VW'($urandom), TW'($urandom),
                    $urandom_range(99) < 30, VW'($urandom), TW'($urandom),
                    $urandom_range(99) < pp, $urandom_range(299) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
